board_updater_n: RTL and testbench
==================================

# board_updater_n

Parametrised successor to the fixed 9x9 board updater for an N x N Go board. It takes a board snapshot, the side to move and a move, then places the stone. It removes captured opponent groups and checks the move for suicide and simple ko using a sequential liberty flood-fill. It returns the committed board, a legality verdict and the capture count. It sits between move entry and the game-state register, and downstream logic commits `next_board` only when `move_legal` is high.

## Interface
- `BOARD_SIZE`, default 9: board edge length N, 2..16.
- `COORD_W`, default 4: bits per coordinate; 2^COORD_W > BOARD_SIZE.
- `KO_EN`, default 1: 1 enables the simple-ko check; 0 never reports ko.
- `clk_in` in 1: single clock; all logic is on its rising edge.
- `rst_n_in` in 1: reset, synchronous and active-low.
- `start_flag` in 1: request; sampled only in IDLE.
- `board_bus` in 2 x N x N: current board; 00 empty, 01 black, 10 white, 11 blocked (occupied, never a liberty, never captured).
- `turn` in 1: 1 means white moves (stone 10); 0 means black moves (stone 01).
- `move_in` in 2*COORD_W: row = [2*COORD_W-1:COORD_W], col = [COORD_W-1:0]; all-ones means pass.
- `next_board` out 2 x N x N: resulting board; equals `board_bus` when the move is illegal.
- `board_ready` out 1: one-cycle done pulse.
- `move_legal` out 1: verdict for the last request.
- `status` out 2: 00 ok, 01 occupied or off-board, 10 suicide, 11 ko.
- `cap_count` out $clog2(N*N+1): number of opponent stones removed.

## Operation
- States: IDLE, CHECK, SEED_OPP, GROW_OPP, SEED_OWN, GROW_OWN, KO, DONE.
- IDLE: on `start_flag`=1, capture `board_bus` into `work` and `orig`, and latch `turn` and `move_in`. Go to CHECK.
- CHECK:
  - Pass: go to DONE with `work` unchanged, status 00.
  - Row or col >= N, or target point not 00: go to DONE with status 01.
  - Otherwise: write own colour at the target and go to SEED_OPP.
- SEED_x: `alive` = stones of colour x that have at least one orthogonally adjacent 00 point. x is the opponent first, then own.
- GROW_x: `alive_nxt` = `alive` OR (colour-x stones orthogonally adjacent to `alive`).
  - If `alive_nxt` == `alive`: clear every colour-x stone not in `alive` and advance.
  - In GROW_OPP, the popcount of cleared stones is loaded into `cap_cnt_r`.
  - Otherwise: `alive` <= `alive_nxt` and stay in GROW_x.
- After GROW_OWN: if the target point is 00, the move is suicide; go to DONE with status 10. Otherwise go to KO.
- KO: if `KO_EN` and `work` == `prev_board`, go to DONE with status 11. Otherwise go to DONE with status 00.
- DONE:
  - On status 00: `next_board` <= `work`, `move_legal` <= 1, `cap_count` <= `cap_cnt_r`, `prev_board` <= `orig`.
  - On any other status: `next_board` <= `orig`, `move_legal` <= 0, `cap_count` <= 0, `prev_board` unchanged.
  - In both cases pulse `board_ready` and return to IDLE.
- A pass is legal and also updates `prev_board` <= `orig`.

## Timing
- Reset (`rst_n_in`=0 at an edge): state IDLE; `next_board` and `prev_board` all 00; `board_ready`=0, `move_legal`=0, `status`=00, `cap_count`=0.
- Reset takes priority over every state. A request in flight is discarded and no `board_ready` pulse follows.
- Edge 0 is the edge that samples `start_flag`. The input buses matter only at edge 0 and may change afterwards.
- Pass or CHECK failure: `board_ready` is high after edge 2, low after edge 3.
- Legal move with both fixed points reached on the first GROW cycle: `board_ready` is high after edge 7.
- Each extra grow iteration adds one cycle. The worst case is bounded by 2*N*N + 7.
- `start_flag` is ignored outside IDLE, including during the DONE cycle.
- Outputs hold their values between requests.
- Back-to-back requests: `start_flag` may be high in the cycle `board_ready` is high; it is sampled in IDLE.

## Test plan
- Capture (N=9, black to move): white at (0,0), black at (0,1); move row 1, col 0.
  - Required: ready 7 edges after start; (0,0)=00; (1,0)=01; `move_legal`=1; `status`=00; `cap_count`=1.
- Suicide: white at (0,1) and (1,0); black plays (0,0).
  - Required: `status`=10; `move_legal`=0; `next_board`==`board_bus`; `cap_count`=0.
- Occupied and off-board:
  - Move (4,4) onto a 10 stone gives `status`=01 with ready after edge 2.
  - Move row 9, col 0 gives `status`=01.
- Ko: set up a ko shape; black captures one stone (legal); white immediately recaptures the same point.
  - Required: `status`=11 and board unchanged.
  - With `KO_EN`=0, the same recapture is legal.
- Long chain, worst-case latency: a 9-stone snake of white with its single liberty at the far end; black fills that liberty.
  - Required: all 9 stones removed; `cap_count`=9; latency grows by one cycle per grow iteration.
- Reset mid-operation: assert `rst_n_in`=0 for one edge during GROW_OPP.
  - Required: no `board_ready` pulse; all outputs at reset values; the next request behaves normally.
  - Repeat with N=5 and N=13 for parameter coverage.

Source files
------------

// File: rtl/board_updater_n_if.sv
// Request/response bundle for board_updater_n: board snapshot and move in,
// committed board, verdict and capture count out.
interface board_updater_n_if #(
    parameter int unsigned BOARD_SIZE = 9,
    parameter int unsigned COORD_W    = 4
);
    localparam int unsigned BW   = 2 * BOARD_SIZE * BOARD_SIZE;
    localparam int unsigned CAPW = $clog2(BOARD_SIZE * BOARD_SIZE + 1);

    logic                   start_flag;
    logic [BW-1:0]          board_bus;
    logic                   turn;
    logic [2*COORD_W-1:0]   move_in;
    logic [BW-1:0]          next_board;
    logic                   board_ready;
    logic                   move_legal;
    logic [1:0]             status;
    logic [CAPW-1:0]        cap_count;

    modport master (
        output start_flag, board_bus, turn, move_in,
        input  next_board, board_ready, move_legal, status, cap_count
    );

    modport slave (
        input  start_flag, board_bus, turn, move_in,
        output next_board, board_ready, move_legal, status, cap_count
    );
endinterface

// File: rtl/board_updater_n.sv
// N x N Go move applier: places a stone, removes captured groups with a
// sequential liberty flood-fill, and rejects occupied, suicide and ko moves.
module board_updater_n #(
    parameter int unsigned BOARD_SIZE = 9,
    parameter int unsigned COORD_W    = 4,
    parameter bit          KO_EN      = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    board_updater_n_if.slave bus
);
    localparam int unsigned NN   = BOARD_SIZE * BOARD_SIZE;
    localparam int unsigned BW   = 2 * NN;
    localparam int unsigned MW   = 2 * COORD_W;
    localparam int unsigned CAPW = $clog2(NN + 1);
    localparam int          NI   = int'(BOARD_SIZE);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_OCC  = 2'b01;
    localparam logic [1:0] ST_SUIC = 2'b10;
    localparam logic [1:0] ST_KO   = 2'b11;

    typedef enum logic [2:0] {
        IDLE, CHECK, SEED_OPP, GROW_OPP, SEED_OWN, GROW_OWN, KO, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     work, work_nxt;
    logic [BW-1:0]     orig, orig_nxt;
    logic [BW-1:0]     prev_board, prev_nxt;
    logic [NN-1:0]     alive, alive_nxt;
    logic              turn_r, turn_nxt;
    logic [MW-1:0]     move_r, move_nxt;
    logic [1:0]        stat_r, stat_nxt;
    logic [CAPW-1:0]   cap_cnt_r, cap_cnt_nxt;

    logic [BW-1:0]     next_board_r, next_board_nxt;
    logic              ready_r, ready_nxt;
    logic              legal_r, legal_nxt;
    logic [1:0]        status_r, status_nxt;
    logic [CAPW-1:0]   cap_out_r, cap_out_nxt;

    logic [1:0]        own_col, opp_col, grp_col;
    logic [NN-1:0]     grp, empty, seed, spread, dead, tgt_mask;
    logic [BW-1:0]     cleared;
    logic [CAPW-1:0]   dead_cnt;
    logic [COORD_W-1:0] row, col;
    logic              is_pass, on_board, tgt_alive;
    logic [1:0]        tgt_cell;

    assign bus.next_board  = next_board_r;
    assign bus.board_ready = ready_r;
    assign bus.move_legal  = legal_r;
    assign bus.status      = status_r;
    assign bus.cap_count   = cap_out_r;

    // Colour of the group currently being flood-filled
    always_comb begin
        own_col = turn_r ? 2'b10 : 2'b01;
        opp_col = turn_r ? 2'b01 : 2'b10;
        grp_col = (state == SEED_OPP || state == GROW_OPP) ? opp_col : own_col;
    end

    always_comb begin
        grp   = '0;
        empty = '0;
        for (int i = 0; i < int'(NN); i++) begin
            grp[i]   = (work[2*i +: 2] == grp_col);
            empty[i] = (work[2*i +: 2] == 2'b00);
        end
    end

    // Liberty seed and one-step orthogonal spread of the alive set
    always_comb begin
        int  idx;
        logic lib_n, reach_n;
        seed   = '0;
        spread = '0;
        idx    = 0;
        lib_n  = 1'b0;
        reach_n = 1'b0;
        for (int r = 0; r < NI; r++) begin
            for (int c = 0; c < NI; c++) begin
                idx     = r * NI + c;
                lib_n   = 1'b0;
                reach_n = alive[idx];
                if (r > 0) begin
                    lib_n   = lib_n   | empty[idx-NI];
                    reach_n = reach_n | alive[idx-NI];
                end
                if (r < NI - 1) begin
                    lib_n   = lib_n   | empty[idx+NI];
                    reach_n = reach_n | alive[idx+NI];
                end
                if (c > 0) begin
                    lib_n   = lib_n   | empty[idx-1];
                    reach_n = reach_n | alive[idx-1];
                end
                if (c < NI - 1) begin
                    lib_n   = lib_n   | empty[idx+1];
                    reach_n = reach_n | alive[idx+1];
                end
                seed[idx]   = grp[idx] & lib_n;
                spread[idx] = grp[idx] & reach_n;
            end
        end
    end

    always_comb begin
        dead     = grp & ~alive;
        cleared  = work;
        dead_cnt = '0;
        for (int i = 0; i < int'(NN); i++) begin
            if (dead[i]) begin
                cleared[2*i +: 2] = 2'b00;
                dead_cnt          = dead_cnt + CAPW'(1);
            end
        end
    end

    // Move decode; target lookup by comparison avoids out-of-range indexing
    always_comb begin
        int tgt;
        row       = move_r[MW-1:COORD_W];
        col       = move_r[COORD_W-1:0];
        is_pass   = &move_r;
        on_board  = (int'(row) < NI) && (int'(col) < NI);
        tgt       = int'(row) * NI + int'(col);
        tgt_mask  = '0;
        tgt_cell  = 2'b00;
        tgt_alive = 1'b0;
        for (int i = 0; i < int'(NN); i++) begin
            if (on_board && i == tgt) begin
                tgt_mask[i] = 1'b1;
                tgt_cell    = work[2*i +: 2];
                tgt_alive   = alive[i];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        work_nxt       = work;
        orig_nxt       = orig;
        prev_nxt       = prev_board;
        alive_nxt      = alive;
        turn_nxt       = turn_r;
        move_nxt       = move_r;
        stat_nxt       = stat_r;
        cap_cnt_nxt    = cap_cnt_r;
        next_board_nxt = next_board_r;
        ready_nxt      = 1'b0;
        legal_nxt      = legal_r;
        status_nxt     = status_r;
        cap_out_nxt    = cap_out_r;

        case (state)
            IDLE: begin
                if (bus.start_flag) begin
                    work_nxt    = bus.board_bus;
                    orig_nxt    = bus.board_bus;
                    turn_nxt    = bus.turn;
                    move_nxt    = bus.move_in;
                    cap_cnt_nxt = '0;
                    state_nxt   = CHECK;
                end
            end
            CHECK: begin
                if (is_pass) begin
                    stat_nxt  = ST_OK;
                    state_nxt = DONE;
                end else if (!on_board || tgt_cell != 2'b00) begin
                    stat_nxt  = ST_OCC;
                    state_nxt = DONE;
                end else begin
                    for (int i = 0; i < int'(NN); i++) begin
                        if (tgt_mask[i]) work_nxt[2*i +: 2] = own_col;
                    end
                    stat_nxt  = ST_OK;
                    state_nxt = SEED_OPP;
                end
            end
            SEED_OPP: begin
                alive_nxt = seed;
                state_nxt = GROW_OPP;
            end
            GROW_OPP: begin
                if (spread == alive) begin
                    work_nxt    = cleared;
                    cap_cnt_nxt = dead_cnt;
                    state_nxt   = SEED_OWN;
                end else begin
                    alive_nxt = spread;
                end
            end
            SEED_OWN: begin
                alive_nxt = seed;
                state_nxt = GROW_OWN;
            end
            GROW_OWN: begin
                if (spread == alive) begin
                    work_nxt = cleared;
                    // The placed stone is removed only if its own group died
                    if (!tgt_alive) begin
                        stat_nxt  = ST_SUIC;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = KO;
                    end
                end else begin
                    alive_nxt = spread;
                end
            end
            KO: begin
                stat_nxt  = (KO_EN && work == prev_board) ? ST_KO : ST_OK;
                state_nxt = DONE;
            end
            DONE: begin
                ready_nxt  = 1'b1;
                status_nxt = stat_r;
                if (stat_r == ST_OK) begin
                    next_board_nxt = work;
                    legal_nxt      = 1'b1;
                    cap_out_nxt    = cap_cnt_r;
                    prev_nxt       = orig;
                end else begin
                    next_board_nxt = orig;
                    legal_nxt      = 1'b0;
                    cap_out_nxt    = '0;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            work         <= '0;
            orig         <= '0;
            prev_board   <= '0;
            alive        <= '0;
            turn_r       <= 1'b0;
            move_r       <= '0;
            stat_r       <= ST_OK;
            cap_cnt_r    <= '0;
            next_board_r <= '0;
            ready_r      <= 1'b0;
            legal_r      <= 1'b0;
            status_r     <= ST_OK;
            cap_out_r    <= '0;
        end else begin
            state        <= state_nxt;
            work         <= work_nxt;
            orig         <= orig_nxt;
            prev_board   <= prev_nxt;
            alive        <= alive_nxt;
            turn_r       <= turn_nxt;
            move_r       <= move_nxt;
            stat_r       <= stat_nxt;
            cap_cnt_r    <= cap_cnt_nxt;
            next_board_r <= next_board_nxt;
            ready_r      <= ready_nxt;
            legal_r      <= legal_nxt;
            status_r     <= status_nxt;
            cap_out_r    <= cap_out_nxt;
        end
    end
endmodule

// File: tb/tb_board_updater_n.sv
// Scoreboard bench for board_updater_n: N=9 with and without ko, plus N=5 and
// N=13, driven by hand-computed directed moves.
module tb_board_updater_n;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   start;
    logic [511:0] board_r;
    logic         turn_r;
    logic [7:0]   move_r;

    logic         ready [4];
    logic         legal [4];
    logic [1:0]   stat  [4];
    logic [7:0]   cap   [4];
    logic [511:0] nb    [4];

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        string        tag;
        int           id;
        logic [511:0] board;
        logic         legal;
        logic [1:0]   status;
        int           cap;
        int           lat;
        int           c0;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    board_updater_n_if #(.BOARD_SIZE(9),  .COORD_W(4)) if0 ();
    board_updater_n_if #(.BOARD_SIZE(9),  .COORD_W(4)) if1 ();
    board_updater_n_if #(.BOARD_SIZE(5),  .COORD_W(4)) if2 ();
    board_updater_n_if #(.BOARD_SIZE(13), .COORD_W(4)) if3 ();

    board_updater_n #(.BOARD_SIZE(9),  .COORD_W(4), .KO_EN(1'b1)) dut0 (.clk_in(clk), .rst_n_in(rst_n), .bus(if0.slave));
    board_updater_n #(.BOARD_SIZE(9),  .COORD_W(4), .KO_EN(1'b0)) dut1 (.clk_in(clk), .rst_n_in(rst_n), .bus(if1.slave));
    board_updater_n #(.BOARD_SIZE(5),  .COORD_W(4), .KO_EN(1'b1)) dut2 (.clk_in(clk), .rst_n_in(rst_n), .bus(if2.slave));
    board_updater_n #(.BOARD_SIZE(13), .COORD_W(4), .KO_EN(1'b1)) dut3 (.clk_in(clk), .rst_n_in(rst_n), .bus(if3.slave));

    assign if0.start_flag = start[0];
    assign if1.start_flag = start[1];
    assign if2.start_flag = start[2];
    assign if3.start_flag = start[3];
    assign if0.board_bus  = board_r[161:0];
    assign if1.board_bus  = board_r[161:0];
    assign if2.board_bus  = board_r[49:0];
    assign if3.board_bus  = board_r[337:0];
    assign if0.turn = turn_r;  assign if1.turn = turn_r;
    assign if2.turn = turn_r;  assign if3.turn = turn_r;
    assign if0.move_in = move_r;  assign if1.move_in = move_r;
    assign if2.move_in = move_r;  assign if3.move_in = move_r;

    assign ready[0] = if0.board_ready;  assign ready[1] = if1.board_ready;
    assign ready[2] = if2.board_ready;  assign ready[3] = if3.board_ready;
    assign legal[0] = if0.move_legal;   assign legal[1] = if1.move_legal;
    assign legal[2] = if2.move_legal;   assign legal[3] = if3.move_legal;
    assign stat[0]  = if0.status;       assign stat[1]  = if1.status;
    assign stat[2]  = if2.status;       assign stat[3]  = if3.status;
    assign cap[0]   = 8'(if0.cap_count);
    assign cap[1]   = 8'(if1.cap_count);
    assign cap[2]   = 8'(if2.cap_count);
    assign cap[3]   = 8'(if3.cap_count);
    assign nb[0]    = 512'(if0.next_board);
    assign nb[1]    = 512'(if1.next_board);
    assign nb[2]    = 512'(if2.next_board);
    assign nb[3]    = 512'(if3.next_board);

    function automatic logic [511:0] put(input logic [511:0] b, input int n,
                                         input int r, input int c, input logic [1:0] v);
        logic [511:0] t;
        t = b;
        t[2*(r*n+c) +: 2] = v;
        return t;
    endfunction

    function automatic logic [7:0] mv(input int r, input int c);
        return {4'(r), 4'(c)};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (ready[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_ready dut%0d: board_ready got 1 expected 0", k);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_dut"},     512'(k),             512'(e.id));
                    chk({e.tag, "_board"},   nb[k],               e.board);
                    chk({e.tag, "_legal"},   512'(legal[k]),      512'(e.legal));
                    chk({e.tag, "_status"},  512'(stat[k]),       512'(e.status));
                    chk({e.tag, "_cap"},     512'(cap[k]),        512'(e.cap));
                    chk({e.tag, "_latency"}, 512'(cyc - e.c0),    512'(e.lat));
                end
            end
        end
    end

    task automatic issue(input string tag, input int id, input logic [511:0] b,
                         input logic t, input logic [7:0] m, input logic [511:0] eb,
                         input logic el, input logic [1:0] es, input int ec, input int lat);
        exp_t e;
        @(negedge clk);
        board_r   = b;
        turn_r    = t;
        move_r    = m;
        start[id] = 1'b1;
        e.tag = tag; e.id = id; e.board = eb; e.legal = el;
        e.status = es; e.cap = ec; e.lat = lat; e.c0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start[id] = 1'b0;
        board_r   = ~b;
        turn_r    = ~t;
        move_r    = m ^ 8'h5A;
        for (int n = 0; n < 400 && sb.size() != 0; n++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: board_ready never seen, required within 400 cycles", tag);
            sb.delete();
        end else begin
            @(negedge clk);
            chk({tag, "_ready_low"}, 512'(ready[id]), 512'(0));
        end
    endtask

    // Abort a request while the opponent flood-fill is running
    task automatic reset_mid(input string tag, input int id, input logic [511:0] b,
                             input logic t, input logic [7:0] m);
        @(negedge clk);
        board_r = b; turn_r = t; move_r = m; start[id] = 1'b1;
        @(negedge clk);
        start[id] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk({tag, "_rst_board"},  nb[id],             512'(0));
        chk({tag, "_rst_legal"},  512'(legal[id]),    512'(0));
        chk({tag, "_rst_status"}, 512'(stat[id]),     512'(0));
        chk({tag, "_rst_cap"},    512'(cap[id]),      512'(0));
        chk({tag, "_rst_ready"},  512'(ready[id]),    512'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [511:0] a, e, a0, b1;
        int n;
        rst_n = 1'b0; start = '0; board_r = '0; turn_r = 1'b0; move_r = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_board",  nb[0],            512'(0));
        chk("reset_legal",  512'(legal[0]),   512'(0));
        chk("reset_status", 512'(stat[0]),    512'(0));
        chk("reset_cap",    512'(cap[0]),     512'(0));
        chk("reset_ready",  512'(ready[0]),   512'(0));

        a = put(put('0, 9, 0, 0, W), 9, 0, 1, B);
        e = put(put('0, 9, 0, 1, B), 9, 1, 0, B);
        issue("capture", 0, a, 1'b0, mv(1, 0), e, 1'b1, 2'b00, 1, 7);

        a = put(put('0, 9, 0, 1, W), 9, 1, 0, W);
        issue("suicide", 0, a, 1'b0, mv(0, 0), a, 1'b0, 2'b10, 0, 6);

        a = put('0, 9, 4, 4, W);
        issue("occupied", 0, a, 1'b0, mv(4, 4), a, 1'b0, 2'b01, 0, 2);

        a = put('0, 9, 8, 8, B);
        issue("offboard", 0, a, 1'b0, mv(9, 0), a, 1'b0, 2'b01, 0, 2);

        a = put('0, 9, 3, 3, B);
        issue("pass", 0, a, 1'b1, 8'hFF, a, 1'b1, 2'b00, 0, 2);

        a0 = '0;
        a0 = put(a0, 9, 0, 1, B); a0 = put(a0, 9, 1, 0, B); a0 = put(a0, 9, 2, 1, B);
        a0 = put(a0, 9, 0, 2, W); a0 = put(a0, 9, 1, 3, W); a0 = put(a0, 9, 2, 2, W);
        a0 = put(a0, 9, 1, 1, W);
        b1 = put(put(a0, 9, 1, 1, 2'b00), 9, 1, 2, B);
        issue("ko_take",   0, a0, 1'b0, mv(1, 2), b1, 1'b1, 2'b00, 1, 7);
        issue("ko_retake", 0, b1, 1'b1, mv(1, 1), b1, 1'b0, 2'b11, 0, 7);
        issue("noko_take",   1, a0, 1'b0, mv(1, 2), b1, 1'b1, 2'b00, 1, 7);
        issue("noko_retake", 1, b1, 1'b1, mv(1, 1), a0, 1'b1, 2'b00, 1, 7);

        a = '0;
        for (int c = 0; c < 9; c++) a = put(a, 9, 0, c, W);
        for (int c = 0; c < 7; c++) a = put(a, 9, 1, c, B);
        e = put(a, 9, 1, 7, B);
        issue("chain_grow", 0, a, 1'b0, mv(1, 7), e, 1'b1, 2'b00, 0, 15);
        a = e;
        e = '0;
        for (int c = 0; c < 9; c++) e = put(e, 9, 1, c, B);
        issue("chain_capture", 0, a, 1'b0, mv(1, 8), e, 1'b1, 2'b00, 9, 7);

        for (int k = 2; k < 4; k++) begin
            n = (k == 2) ? 5 : 13;
            a = put(put('0, n, 0, 0, W), n, 0, 1, B);
            e = put(put('0, n, 0, 1, B), n, 1, 0, B);
            issue($sformatf("capture_n%0d", n), k, a, 1'b0, mv(1, 0), e, 1'b1, 2'b00, 1, 7);
            reset_mid($sformatf("midreset_n%0d", n), k, a, 1'b0, mv(1, 0));
            issue($sformatf("after_reset_n%0d", n), k, a, 1'b0, mv(1, 0), e, 1'b1, 2'b00, 1, 7);
        end

        a = put(put('0, 9, 0, 0, W), 9, 0, 1, B);
        e = put(put('0, 9, 0, 1, B), 9, 1, 0, B);
        issue("capture_n9", 0, a, 1'b0, mv(1, 0), e, 1'b1, 2'b00, 1, 7);
        reset_mid("midreset_n9", 0, a, 1'b0, mv(1, 0));
        issue("after_reset_n9", 0, a, 1'b0, mv(1, 0), e, 1'b1, 2'b00, 1, 7);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
